// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
//
// Hazard and stall controller for a classic five-stage pipeline. It resolves
// three kinds of event, in priority order:
//   1. data-cache miss   -> freeze PC, IF/ID and EX/MEM until the refill is done
//   2. branch taken (EX) -> squash the two younger instructions (IF/ID, ID/EX)
//   3. load-use hazard   -> hold PC and IF/ID for one cycle, bubble into ID/EX
// A lower-priority event that coincides with a higher one is simply dropped;
// the frozen pipeline presents it again once the higher one clears.
//
// All control outputs are combinational from the FSM state and the inputs,
// so they act in the same cycle the event is seen.
//
// Optional feature (compile-time macro MISS_TIMEOUT_EN):
//   An 8-bit timer counts MISS_WAIT cycles. If the 255th MISS_WAIT cycle ends
//   without mem_ready, timeout_err is set (sticky until rst) and the FSM
//   returns to RUN. Without the macro there is no timer, timeout_err is tied
//   low and MISS_WAIT waits indefinitely.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   id_rs, id_rt    source register fields of the instruction in ID
//   ex_mem_read     instruction in ID/EX is a load
//   ex_rt           destination register of the instruction in ID/EX
//   branch_taken    branch in EX resolved taken
//   mem_access      MEM stage performs a load or store
//   hit             data-cache hit for that access
//   mem_ready       one-cycle pulse: refill complete
//   pc_write        PC register enable
//   if_id_write     IF/ID register enable
//   if_id_flush     bubble into IF/ID
//   id_ex_flush     bubble into ID/EX
//   ex_mem_hold     freeze EX/MEM
//   miss_busy       miss being serviced (MISS_WAIT or REFILL)
//   stall_cnt       saturating count of cycles with pc_write low
//   timeout_err     sticky miss-timeout flag
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        branch_taken,
  input  logic        mem_access,
  input  logic        hit,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_hold,
  output logic        miss_busy,
  output logic [15:0] stall_cnt,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MISS_WAIT = 2'd1,
    REFILL    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic miss_det;
  logic load_use;
  logic timeout_hit;

  assign miss_det = mem_access & ~hit;

  // Register 0 is hard-wired zero, so a load "into" it never creates a hazard.
  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

`ifdef MISS_TIMEOUT_EN
  logic [7:0] miss_timer;

  // The timer sits at zero outside MISS_WAIT, so it is already cleared on
  // entry. During the k-th MISS_WAIT cycle it holds k-1; the 255th cycle
  // therefore sees 254.
  assign timeout_hit = (state == MISS_WAIT) && !mem_ready &&
                       (miss_timer == 8'd254);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_timer  <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      if (state == MISS_WAIT) miss_timer <= miss_timer + 8'd1;
      else                    miss_timer <= 8'd0;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // NOTE: every output is given a default before any branch so that no path
  // leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt   = state;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_hold = 1'b0;
    miss_busy   = 1'b0;

    // Reset forces every control output low, independent of the state.
    if (rst) begin
      state_nxt = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (miss_det) begin
            // mem_ready in the detection cycle belongs to no miss yet.
            ex_mem_hold = 1'b1;
            state_nxt   = MISS_WAIT;
          end else if (branch_taken) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            id_ex_flush = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end

        MISS_WAIT: begin
          ex_mem_hold = 1'b1;
          miss_busy   = 1'b1;
          if (mem_ready)        state_nxt = REFILL;
          else if (timeout_hit) state_nxt = RUN;
        end

        REFILL: begin
          // One cycle for the refilled data to be captured; mem_ready ignored.
          ex_mem_hold = 1'b1;
          miss_busy   = 1'b1;
          state_nxt   = RUN;
        end

        default: state_nxt = RUN;
      endcase
    end
  end

  // NOTE: only control state needs a reset; the counter is reset because its
  // value is architecturally visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (!pc_write && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
//
// Directed scenarios followed by a randomized run. A behavioural model tracks
// "is a miss being serviced, how long has it waited, has the data arrived"
// and derives the expected control word from the priority rules each cycle.
// Inputs change 1 time unit after the rising edge; outputs are compared 3
// units later, well before the next edge.
// -----------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

`ifdef MISS_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        ex_mem_read, branch_taken, mem_access, hit, mem_ready;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic        ex_mem_hold, miss_busy, timeout_err;
  logic [15:0] stall_cnt;

  pipeline_stall_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .mem_access   (mem_access),
    .hit          (hit),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_hold  (ex_mem_hold),
    .miss_busy    (miss_busy),
    .stall_cnt    (stall_cnt),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  bit m_in_miss;     // a miss has been detected and not yet finished
  bit m_data_back;   // mem_ready seen for the current miss (refill cycle next)
  int m_waited;      // cycles spent waiting for the data
  int m_stalls;      // cycles with PC held
  bit m_timeout;

  // Control word order: {pc_write, if_id_write, if_id_flush, id_ex_flush,
  //                      ex_mem_hold, miss_busy}
  logic [5:0]  exp_ctl;
  logic [5:0]  obs_ctl;
  logic [15:0] obs_stall;
  logic        obs_to;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
  endtask

  task automatic idle();
    id_rs = 5'd1; id_rt = 5'd2; ex_rt = 5'd3; ex_mem_read = 1'b0;
    branch_taken = 1'b0; mem_access = 1'b0; hit = 1'b1; mem_ready = 1'b0;
  endtask

  // One clock cycle: predict, compare, advance the model across the edge.
  task automatic run_cycle(input string tag);
    logic miss, lu;
    if (rst) begin
      m_in_miss = 0; m_data_back = 0; m_waited = 0; m_stalls = 0; m_timeout = 0;
    end
    miss = mem_access && !hit;
    lu   = ex_mem_read && (ex_rt != 5'd0) && (ex_rt == id_rs || ex_rt == id_rt);
    if (rst)               exp_ctl = 6'b000000;
    else if (m_in_miss)    exp_ctl = 6'b000011;
    else if (miss)         exp_ctl = 6'b000010;
    else if (branch_taken) exp_ctl = 6'b111100;
    else if (lu)           exp_ctl = 6'b000100;
    else                   exp_ctl = 6'b110000;
    #3;
    obs_ctl   = {pc_write, if_id_write, if_id_flush, id_ex_flush,
                 ex_mem_hold, miss_busy};
    obs_stall = stall_cnt;
    obs_to    = timeout_err;
    check({tag, ":ctl"},     {26'd0, obs_ctl},   {26'd0, exp_ctl});
    check({tag, ":stall"},   {16'd0, obs_stall}, m_stalls);
    check({tag, ":timeout"}, {31'd0, obs_to},    {31'd0, m_timeout});
    @(posedge clk);
    if (!rst) begin
      if (!exp_ctl[5] && m_stalls < 65535) m_stalls++;
      if (m_in_miss) begin
        if (m_data_back) m_in_miss = 0;
        else begin
          m_waited++;
          if (mem_ready) m_data_back = 1;
          else if (TIMEOUT_EN && m_waited == 255) begin
            m_in_miss = 0;
            m_timeout = 1;
          end
        end
      end else if (miss) begin
        m_in_miss = 1; m_data_back = 0; m_waited = 0;
      end
    end
    #1;
  endtask

  initial begin
    int holds;
    logic [15:0] s0;

    rst = 1'b0;
    idle();
    #1 rst = 1'b1;

    // Reset state.
    run_cycle("reset0");
    check("reset_ctl_zero", {26'd0, obs_ctl}, 32'd0);
    run_cycle("reset1");
    rst = 1'b0;
    run_cycle("idle");
    check("idle_pc_write", {31'd0, obs_ctl[5]}, 32'd1);

    // Load-use on rs: one stall cycle, counter 0 -> 1.
    ex_mem_read = 1'b1; ex_rt = 5'd12; id_rs = 5'd12;
    run_cycle("load_use");
    check("load_use_ctl", {26'd0, obs_ctl}, {26'd0, 6'b000100});
    idle();
    run_cycle("after_load_use");
    check("load_use_stall_cnt", {16'd0, obs_stall}, 32'd1);

    // Load into r0 never stalls.
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    run_cycle("r0_load");
    check("r0_no_stall", {31'd0, obs_ctl[5]}, 32'd1);

    // Load-use on rt as well.
    idle(); ex_mem_read = 1'b1; ex_rt = 5'd7; id_rt = 5'd7;
    run_cycle("load_use_rt");

    // Branch beats load-use.
    ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; branch_taken = 1'b1;
    run_cycle("branch_over_lu");
    check("branch_over_lu_ctl", {26'd0, obs_ctl}, {26'd0, 6'b111100});

    // Miss with branch and mem_ready in the detection cycle: freeze only.
    idle(); mem_access = 1'b1; hit = 1'b0; branch_taken = 1'b1; mem_ready = 1'b1;
    run_cycle("miss_detect");
    check("miss_over_branch", {26'd0, obs_ctl}, {26'd0, 6'b000010});
    s0 = obs_stall;
    holds = int'(obs_ctl[1]);
    idle();
    repeat (4) begin
      run_cycle("miss_wait");
      holds += int'(obs_ctl[1]);
    end
    mem_ready = 1'b1;
    run_cycle("miss_ready");
    holds += int'(obs_ctl[1]);
    mem_ready = 1'b0;
    run_cycle("refill");
    holds += int'(obs_ctl[1]);
    run_cycle("after_miss");
    holds += int'(obs_ctl[1]);
    check("miss_hold_cycles", holds, 32'd7);
    check("miss_stall_delta", {16'd0, obs_stall - s0}, 32'd7);
    check("after_miss_run", {26'd0, obs_ctl}, {26'd0, 6'b110000});

    // mem_ready in RUN is ignored; mem_ready held through REFILL is ignored.
    mem_ready = 1'b1;
    run_cycle("ready_in_run");
    idle(); mem_access = 1'b1; hit = 1'b0;
    run_cycle("miss2_detect");
    idle();
    run_cycle("miss2_wait");
    mem_ready = 1'b1;
    run_cycle("miss2_ready");
    run_cycle("miss2_refill_ready");
    run_cycle("miss2_after");
    idle();
    run_cycle("miss2_idle");

    // Reset in the middle of MISS_WAIT.
    mem_access = 1'b1; hit = 1'b0;
    run_cycle("miss3_detect");
    idle();
    repeat (2) run_cycle("miss3_wait");
    rst = 1'b1;
    run_cycle("miss3_reset");
    check("mid_miss_reset_zero", {26'd0, obs_ctl}, 32'd0);
    rst = 1'b0;
    run_cycle("miss3_release");
    check("release_pc_write", {31'd0, obs_ctl[5]}, 32'd1);
    check("release_not_busy", {31'd0, obs_ctl[0]}, 32'd0);

`ifdef MISS_TIMEOUT_EN
    // Miss with no data: timeout after 255 waiting cycles, then RUN.
    mem_access = 1'b1; hit = 1'b0;
    run_cycle("to_detect");
    idle();
    repeat (255) run_cycle("to_wait");
    run_cycle("to_after");
    check("timeout_set", {31'd0, obs_to}, 32'd1);
    check("timeout_run", {26'd0, obs_ctl}, {26'd0, 6'b110000});
    repeat (3) run_cycle("to_sticky");
    check("timeout_sticky", {31'd0, obs_to}, 32'd1);
    rst = 1'b1;
    run_cycle("to_reset");
    rst = 1'b0;
    run_cycle("to_cleared");
    check("timeout_cleared", {31'd0, obs_to}, 32'd0);
`endif

    // Randomized traffic with small register numbers to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 59) == 0);
      mem_access   = ($urandom_range(0, 3) == 0);
      hit          = ($urandom_range(0, 2) != 0);
      mem_ready    = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 4) == 0);
      ex_mem_read  = $urandom_range(0, 1) == 1;
      ex_rt        = 5'($urandom_range(0, 3));
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      run_cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; all state changes on the rising edge of clk.
REQ-002 SHALL have port: clk  input  1  pipeline clock.
REQ-003 SHALL have port: rst  input  1  async active-high reset.
REQ-004 SHALL have port: id_rs  input  5  rs field of the instruction in ID.
REQ-005 SHALL have port: id_rt  input  5  rt field of the instruction in ID.
REQ-006 SHALL have port: ex_mem_read  input  1  MEM_Read held in ID/EX.
REQ-007 SHALL have port: ex_rt  input  5  RT held in ID/EX.
REQ-008 SHALL have port: branch_taken  input  1  EX-stage branch resolved taken.
REQ-009 SHALL have port: mem_access  input  1  MEM stage performing a load or store.
REQ-010 SHALL have port: hit  input  1  data-cache hit for the MEM access.
REQ-011 SHALL have port: mem_ready  input  1  refill complete, one-cycle pulse.
REQ-012 SHALL have outputs pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold, miss_busy (all 1 bit): PC enable, IF/ID enable, IF/ID bubble, ID/EX bubble, EX/MEM freeze, miss in progress.
REQ-013 SHALL have output stall_cnt  16 bits  saturating count of stalled cycles.
REQ-014 SHALL have output timeout_err  1 bit  sticky miss-timeout flag.

Function
REQ-015 SHALL implement FSM states RUN, MISS_WAIT, REFILL.
REQ-016 RUN, mem_access=1 and hit=0: same cycle pc_write=0, if_id_write=0, ex_mem_hold=1, both flushes 0; next state MISS_WAIT.
REQ-017 MISS_WAIT: same freeze outputs and miss_busy=1; mem_ready=1 -> REFILL; else remain.
REQ-018 REFILL: freeze held exactly one cycle, miss_busy=1; then RUN unconditionally.
REQ-019 RUN, no miss, branch_taken=1: if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_write=1.
REQ-020 RUN, no miss, no branch, load-use (ex_mem_read=1, ex_rt!=0, ex_rt==id_rs or ex_rt==id_rt): pc_write=0, if_id_write=0, id_ex_flush=1, same cycle, one cycle per occurrence.
REQ-021 Priority: miss > branch_taken > load-use; lower-priority events are ignored that cycle and re-presented by the frozen pipeline.
REQ-022 No event in RUN: pc_write=1, if_id_write=1, all other control outputs 0.
REQ-023 All control outputs are combinational from state and inputs, with zero-cycle latency.
REQ-024 stall_cnt SHALL increment on each cycle with pc_write=0 (rst low) and saturate at 16'hFFFF.
REQ-025 mem_ready while in RUN or REFILL SHALL be ignored.
REQ-026 mem_ready in the same cycle the miss is detected (RUN) SHALL be ignored; MISS_WAIT is still entered.

Reset
REQ-027 While rst=1: state=RUN; stall_cnt=0; timeout_err=0; pc_write, if_id_write, flushes, ex_mem_hold, miss_busy all 0.
REQ-028 Reset asserted mid-miss SHALL abandon the miss immediately; after release the FSM is in RUN with no residual freeze.

Configuration
REQ-029 Macro MISS_TIMEOUT_EN defined: an 8-bit counter clears on entry to MISS_WAIT and increments each MISS_WAIT cycle. At 255 without mem_ready, timeout_err sets (sticky until rst) and the FSM goes to RUN.
REQ-030 MISS_TIMEOUT_EN undefined: no counter; timeout_err tied 0; MISS_WAIT waits indefinitely.

Verification
REQ-031 Load-use: ex_mem_read=1, ex_rt=12, id_rs=12 -> one cycle pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt 0->1.
REQ-032 ex_rt=0, ex_mem_read=1, id_rs=0 -> no stall; pc_write=1.
REQ-033 Miss: mem_access=1, hit=0; mem_ready pulse after 5 cycles -> ex_mem_hold=1 for 1+5+1 cycles, then RUN; stall_cnt=7.
REQ-034 branch_taken=1 with load-use present -> both flushes 1, pc_write=1; branch_taken=1 with miss -> freeze only, no flush.
REQ-035 rst pulse during MISS_WAIT -> all outputs 0 during rst; next cycle pc_write=1, miss_busy=0.
REQ-036 MISS_TIMEOUT_EN: miss with no mem_ready -> timeout_err=1 after 255 MISS_WAIT cycles, RUN next cycle, flag held until rst.
